// File: rtl/mem.sv
// MEM pipeline stage: byte-serial load/store over an 8-bit RAM port.
// Stalls upstream until the access completes, then presents the write-back triple.
//
// state | meaning
// IDLE  | pass-through for non-memory ops; memory op seen -> start access
// REQ   | issuing byte requests, one per grant
// WAIT  | last read byte arrives this cycle
// DONE  | result presented; held here while MEM/WB is stalled
module mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_memaddr,
    input  logic        mem_memwr,
    input  logic [1:0]  mem_memcnf,
    input  logic        mem_memsigned,
    input  logic        stall_in,
    input  logic        ram_gnt,
    input  logic [7:0]  ram_rdata,
    output logic        ram_req,
    output logic        ram_wr,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        mem_stall_req,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic [31:0] buf_q, buf_d;
    logic [1:0]  last_idx;
    logic [31:0] load_val;

    always_comb begin
        case (mem_memcnf)
            2'd1:    last_idx = 2'd0;
            2'd2:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    always_comb begin
        case (mem_memcnf)
            2'd1:    load_val = {{24{mem_memsigned & buf_q[7]}}, buf_q[7:0]};
            2'd2:    load_val = {{16{mem_memsigned & buf_q[15]}}, buf_q[15:0]};
            default: load_val = buf_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            buf_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            buf_q      <= buf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pend_d        = 1'b0;
        pend_idx_d    = pend_idx_q;
        buf_d         = buf_q;
        ram_req       = 1'b0;
        ram_wr        = 1'b0;
        ram_addr      = 32'd0;
        ram_wdata     = 8'd0;
        mem_stall_req = 1'b0;
        wb_wd         = 5'd0;
        wb_wreg       = 1'b0;
        wb_wdata      = 32'd0;

        // Read data lags its grant by one cycle, regardless of the current grant.
        if (pend_q) begin
            buf_d[{pend_idx_q, 3'b000} +: 8] = ram_rdata;
        end

        case (state_q)
            IDLE: begin
                if (mem_memcnf == 2'd0) begin
                    wb_wd    = mem_wd;
                    wb_wreg  = mem_wreg;
                    wb_wdata = mem_wdata;
                end else begin
                    mem_stall_req = 1'b1;
                    idx_d         = 2'd0;
                    buf_d         = 32'd0;
                    state_d       = REQ;
                end
            end
            REQ: begin
                mem_stall_req = 1'b1;
                ram_req       = 1'b1;
                ram_wr        = mem_memwr;
                ram_addr      = mem_memaddr + {30'd0, idx_q};
                ram_wdata     = mem_wdata[{idx_q, 3'b000} +: 8];
                if (ram_gnt) begin
                    idx_d      = idx_q + 2'd1;
                    pend_d     = ~mem_memwr;
                    pend_idx_d = idx_q;
                    if (idx_q == last_idx) begin
                        state_d = mem_memwr ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                mem_stall_req = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                wb_wd    = mem_wd;
                wb_wreg  = mem_wreg;
                wb_wdata = mem_memwr ? mem_wdata : load_val;
                // Holding here keeps the still-present EX/MEM op from being re-issued.
                if (!stall_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            ram_req       = 1'b0;
            ram_wr        = 1'b0;
            ram_addr      = 32'd0;
            ram_wdata     = 8'd0;
            mem_stall_req = 1'b0;
            wb_wd         = 5'd0;
            wb_wreg       = 1'b0;
            wb_wdata      = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for the MEM stage: directed plan cases plus randomized
// loads/stores against a byte-level transaction model.
module tb_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_memaddr;
    logic        mem_memwr;
    logic [1:0]  mem_memcnf;
    logic        mem_memsigned;
    logic        stall_in;
    logic        ram_gnt;
    logic [7:0]  ram_rdata;
    logic        ram_req;
    logic        ram_wr;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        mem_stall_req;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;

    int vectors = 0;
    int miscompares = 0;

    mem dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_memaddr(mem_memaddr), .mem_memwr(mem_memwr), .mem_memcnf(mem_memcnf),
        .mem_memsigned(mem_memsigned), .stall_in(stall_in),
        .ram_gnt(ram_gnt), .ram_rdata(ram_rdata),
        .ram_req(ram_req), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .mem_stall_req(mem_stall_req),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One memory op from IDLE through DONE (+hold), followed by an idle pass-through cycle.
    // gmode: 0 grant always, 1 grant on alternate cycles, 2 random grants.
    task automatic run_op(input logic [1:0] cnf, input logic wr, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] wd, input logic wreg,
                          input logic [31:0] rd_word, input bit rand_rd,
                          input int gmode, input int hold);
        int          n;
        int          grants;
        int          gaps;
        int          stalls;
        int          cyc;
        bit          done;
        bit          toggle;
        bit          rd_pend;
        logic [7:0]  rd_byte;
        logic [7:0]  rb [4];
        logic [63:0] v;
        logic [31:0] exp;
        logic [31:0] sh;
        logic        g;

        n = (cnf == 2'd3) ? 4 : int'(cnf);
        grants = 0; gaps = 0; stalls = 0; cyc = 0;
        done = 1'b0; toggle = 1'b0; rd_pend = 1'b0; rd_byte = 8'd0;
        for (int k = 0; k < 4; k++) rb[k] = 8'd0;

        @(negedge clk);
        mem_memcnf = cnf; mem_memwr = wr; mem_memsigned = sgn;
        mem_memaddr = addr; mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg;
        stall_in = 1'b0;

        while (!done && cyc < 200) begin
            #1;
            ram_rdata = rd_pend ? rd_byte : 8'($urandom);
            rd_pend = 1'b0;
            if (mem_stall_req) begin
                stalls++;
                chk("stall_wreg", {31'd0, wb_wreg}, 32'd0);
                case (gmode)
                    0:       g = 1'b1;
                    1:       g = toggle;
                    default: g = 1'($urandom_range(1));
                endcase
                if (ram_req) begin
                    toggle = ~toggle;
                    chk("req_addr", ram_addr, addr + 32'(grants));
                    chk("req_wr", {31'd0, ram_wr}, {31'd0, wr});
                    if (wr) begin
                        sh = wdata >> (8 * grants);
                        chk("req_wdata", {24'd0, ram_wdata}, {24'd0, sh[7:0]});
                    end
                    if (g) begin
                        if (!wr && grants < 4) begin
                            rd_byte = rand_rd ? 8'($urandom) : 8'(rd_word >> (8 * grants));
                            rb[grants] = rd_byte;
                            rd_pend = 1'b1;
                        end
                        grants++;
                    end else begin
                        gaps++;
                    end
                end
                ram_gnt = g;
            end else begin
                ram_gnt = 1'b0;
                done = 1'b1;
            end
            cyc++;
            if (!done) @(negedge clk);
        end

        chk("op_done", {31'd0, done}, 32'd1);
        chk("grant_count", 32'(grants), 32'(n));
        chk("stall_cycles", 32'(stalls), 32'(1 + n + gaps + (wr ? 0 : 1)));

        if (wr) begin
            exp = wdata;
        end else begin
            v = 64'd0;
            for (int k = 0; k < n; k++) v = v | (64'(rb[k]) << (8 * k));
            if (sgn && n < 4 && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
            exp = v[31:0];
        end

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(negedge clk);
                #1;
                chk("hold_stall", {31'd0, mem_stall_req}, 32'd0);
            end
            stall_in = (h < hold);
            chk("done_req", {31'd0, ram_req}, 32'd0);
            chk("wb_wd", {27'd0, wb_wd}, {27'd0, wd});
            chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, wreg});
            chk("wb_wdata", wb_wdata, exp);
        end

        @(negedge clk);
        stall_in = 1'b0;
        mem_memcnf = 2'd0;
        mem_wdata = $urandom;
        mem_wd = 5'($urandom);
        mem_wreg = 1'b1;
        #1;
        chk("idle_req", {31'd0, ram_req}, 32'd0);
        chk("idle_stall", {31'd0, mem_stall_req}, 32'd0);
        chk("idle_pass", wb_wdata, mem_wdata);
    endtask

    initial begin
        rst = 1'b1; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF;
        mem_memaddr = 32'h10; mem_memwr = 1'b0; mem_memcnf = 2'd3; mem_memsigned = 1'b1;
        stall_in = 1'b0; ram_gnt = 1'b0; ram_rdata = 8'd0;

        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_req", {31'd0, ram_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall_req}, 32'd0);
        chk("rst_wb", {26'd0, wb_wreg, wb_wd}, 32'd0);
        chk("rst_wdata", wb_wdata, 32'd0);
        chk("rst_addr", ram_addr, 32'd0);

        @(negedge clk);
        rst = 1'b0; mem_memcnf = 2'd0; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
        #1;
        chk("pass_wd", {27'd0, wb_wd}, 32'd5);
        chk("pass_wreg", {31'd0, wb_wreg}, 32'd1);
        chk("pass_wdata", wb_wdata, 32'h1234);
        chk("pass_stall", {31'd0, mem_stall_req}, 32'd0);

        // Load word, back-to-back grants
        run_op(2'd3, 1'b0, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 32'h12345678, 1'b0, 0, 0);
        // LB / LBU of 0x80, LH signed of 0x34,0xF2
        run_op(2'd1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd4, 1'b1, 32'h00000080, 1'b0, 0, 0);
        run_op(2'd1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd4, 1'b1, 32'h00000080, 1'b0, 0, 0);
        run_op(2'd2, 1'b0, 1'b1, 32'h41, 32'h0, 5'd6, 1'b1, 32'h0000F234, 1'b0, 0, 0);
        // Store half with grant gaps, misaligned
        run_op(2'd2, 1'b1, 1'b0, 32'h2001, 32'hAABBCCDD, 5'd0, 1'b0, 32'h0, 1'b1, 1, 0);
        // Store word across address wrap, MEM/WB stalled two cycles in DONE
        run_op(2'd3, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h01020304, 5'd0, 1'b0, 32'h0, 1'b1, 0, 2);

        // Reset in the middle of a load word
        @(negedge clk);
        mem_memcnf = 2'd3; mem_memwr = 1'b0; mem_memsigned = 1'b0;
        mem_memaddr = 32'h300; mem_wd = 5'd9; mem_wreg = 1'b1; ram_gnt = 1'b1;
        @(negedge clk);
        ram_rdata = 8'hAA;
        @(negedge clk);
        ram_rdata = 8'hBB;
        @(negedge clk);
        rst = 1'b1; ram_rdata = 8'hCC; ram_gnt = 1'b0;
        #1;
        chk("midrst_req", {31'd0, ram_req}, 32'd0);
        chk("midrst_stall", {31'd0, mem_stall_req}, 32'd0);
        chk("midrst_wb", {26'd0, wb_wreg, wb_wd}, 32'd0);
        chk("midrst_wdata", wb_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_memcnf = 2'd0;
        #1;
        chk("postrst_req", {31'd0, ram_req}, 32'd0);
        chk("postrst_stall", {31'd0, mem_stall_req}, 32'd0);
        run_op(2'd3, 1'b0, 1'b0, 32'h300, 32'h0, 5'd9, 1'b1, 32'h0000_0011, 1'b0, 0, 0);

        // Randomized loads and stores
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  cnf;
            logic        wr;
            logic [31:0] addr;
            cnf  = 2'($urandom_range(3, 1));
            wr   = 1'($urandom_range(1));
            addr = ($urandom_range(3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(3))) : $urandom;
            run_op(cnf, wr, 1'($urandom_range(1)), addr, $urandom, 5'($urandom),
                   wr ? 1'b0 : 1'($urandom_range(1)), 32'h0, 1'b1,
                   int'($urandom_range(2)), int'($urandom_range(2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
